// File: rtl/coef_bank_biquad.sv
// Coefficient store and sequencer for a time-multiplexed biquad MAC.
// Shadow bank is written by control; active bank is streamed one word per cycle per sample tick.
module coef_bank_biquad #(
  parameter  int CANT_BITS = 25,
  parameter  int FRAC      = 14,
  parameter  int N_FILT    = 3,
  parameter  int N_COEF    = 5,
  localparam int FW        = (N_FILT > 1) ? $clog2(N_FILT) : 1,
  localparam int IW        = (N_COEF > 1) ? $clog2(N_COEF) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [FW-1:0]        wr_filt,
  input  logic [IW-1:0]        wr_idx,
  input  logic [CANT_BITS-1:0] wr_dato,
  input  logic                 commit,
  input  logic [FW-1:0]        sel_filt,
  input  logic                 muestra_tick,
  output logic [CANT_BITS-1:0] cte,
  output logic [IW-1:0]        cte_idx,
  output logic                 cte_valid,
  output logic                 cte_last,
  output logic                 busy,
  output logic                 commit_pend,
  output logic                 overrun
);

  typedef logic [CANT_BITS-1:0] bank_t [N_FILT][N_COEF];
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CANT_BITS-1:0] UNITY = {{(CANT_BITS-1){1'b0}}, 1'b1} << FRAC;

  state_t               state_q, state_d;
  logic [IW-1:0]        k_q, k_d;
  logic [FW-1:0]        sel_q, sel_d;
  bank_t                shadow_q, shadow_d;
  bank_t                active_q, active_d;
  logic                 commit_pend_q, commit_pend_d;
  logic [CANT_BITS-1:0] cte_q, cte_d;
  logic [IW-1:0]        cte_idx_q, cte_idx_d;
  logic                 cte_valid_q, cte_valid_d;
  logic                 cte_last_q, cte_last_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 tick_acc;

  // Out-of-range sets read as passthrough so a bad selector never streams garbage.
  function automatic logic [CANT_BITS-1:0] coef_at(input bank_t b, input logic [FW-1:0] s,
                                                   input logic [IW-1:0] k);
    if (32'(s) < N_FILT) return b[s][k];
    else return (k == '0) ? UNITY : '0;
  endfunction

  // Stream interface: cte/cte_idx/cte_last are meaningful only while cte_valid=1; there is
  // no ready, the MAC must consume one word per cycle for N_COEF consecutive cycles.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_pend_d = commit_pend_q;
    cte_d         = '0;
    cte_idx_d     = '0;
    cte_valid_d   = 1'b0;
    cte_last_d    = 1'b0;
    busy_d        = 1'b0;
    overrun_d     = 1'b0;
    tick_acc      = muestra_tick && (state_q == IDLE);

    if (wr_en && (32'(wr_filt) < N_FILT) && (32'(wr_idx) < N_COEF))
      shadow_d[wr_filt][wr_idx] = wr_dato;

    // Copy from shadow_q so a write landing in the tick cycle is not part of the swap.
    if (tick_acc && commit_pend_q) begin
      active_d      = shadow_q;
      commit_pend_d = 1'b0;
    end
    if (commit) commit_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (muestra_tick) begin
          sel_d       = sel_filt;
          cte_d       = coef_at(active_d, sel_filt, '0);
          cte_valid_d = 1'b1;
          cte_last_d  = (N_COEF == 1);
          busy_d      = 1'b1;
          k_d         = IW'(1);
          state_d     = RUN;
        end
      end
      RUN: begin
        overrun_d = muestra_tick;
        if (cte_last_q) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          cte_d       = coef_at(active_q, sel_q, k_q);
          cte_idx_d   = k_q;
          cte_valid_d = 1'b1;
          cte_last_d  = (k_q == IW'(N_COEF - 1));
          busy_d      = 1'b1;
          k_d         = k_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      sel_q         <= '0;
      commit_pend_q <= 1'b0;
      cte_q         <= '0;
      cte_idx_q     <= '0;
      cte_valid_q   <= 1'b0;
      cte_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int f = 0; f < N_FILT; f++) begin
        for (int c = 0; c < N_COEF; c++) begin
          shadow_q[f][c] <= (c == 0) ? UNITY : '0;
          active_q[f][c] <= (c == 0) ? UNITY : '0;
        end
      end
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      sel_q         <= sel_d;
      commit_pend_q <= commit_pend_d;
      cte_q         <= cte_d;
      cte_idx_q     <= cte_idx_d;
      cte_valid_q   <= cte_valid_d;
      cte_last_q    <= cte_last_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign cte         = cte_q;
  assign cte_idx     = cte_idx_q;
  assign cte_valid   = cte_valid_q;
  assign cte_last    = cte_last_q;
  assign busy        = busy_q;
  assign commit_pend = commit_pend_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_coef_bank_biquad.sv
// Directed bench for coef_bank_biquad: banks, commit timing, overrun, passthrough and reset.
module tb_coef_bank_biquad;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_filt;
  logic [2:0]  wr_idx;
  logic [24:0] wr_dato;
  logic        commit;
  logic [1:0]  sel_filt;
  logic        muestra_tick;
  logic [24:0] cte;
  logic [2:0]  cte_idx;
  logic        cte_valid;
  logic        cte_last;
  logic        busy;
  logic        commit_pend;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  logic [24:0] pass_set [5];
  logic [24:0] set1     [5];
  logic [24:0] set1b    [5];

  always #5 clk = ~clk;

  coef_bank_biquad dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_filt(wr_filt), .wr_idx(wr_idx),
    .wr_dato(wr_dato), .commit(commit), .sel_filt(sel_filt), .muestra_tick(muestra_tick),
    .cte(cte), .cte_idx(cte_idx), .cte_valid(cte_valid), .cte_last(cte_last),
    .busy(busy), .commit_pend(commit_pend), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] f, input logic [2:0] i, input logic [24:0] d);
    wr_en = 1'b1; wr_filt = f; wr_idx = i; wr_dato = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    chk("commit_pend_set", 32'(commit_pend), 32'd1);
  endtask

  // Issues a tick (any write/commit already set up rides in the same cycle) and checks
  // the five-word stream plus the idle cycle after it.
  task automatic stream(input string tag, input logic [1:0] sel, input logic [24:0] e [5]);
    muestra_tick = 1'b1; sel_filt = sel;
    cyc();
    muestra_tick = 1'b0; wr_en = 1'b0; commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(cte_valid), 32'd1);
      chk($sformatf("%s_idx%0d", tag, i), 32'(cte_idx), 32'(i));
      chk($sformatf("%s_cte%0d", tag, i), 32'(cte), 32'(e[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(cte_last), 32'(i == 4));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      cyc();
    end
    chk({tag, "_end_valid"}, 32'(cte_valid), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cte"}, 32'(cte), 32'd0);
    chk({tag, "_idx"}, 32'(cte_idx), 32'd0);
    chk({tag, "_valid"}, 32'(cte_valid), 32'd0);
    chk({tag, "_last"}, 32'(cte_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pend"}, 32'(commit_pend), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    pass_set = '{25'h4000, 25'h0, 25'h0, 25'h0, 25'h0};
    set1     = '{25'h2672, 25'h1FFB323, 25'h2672, 25'h423D, 25'h1FFE876};
    set1b    = '{25'h1234, 25'h1FFB323, 25'h2672, 25'h423D, 25'h1FFE876};
    reset = 1'b1; wr_en = 1'b0; wr_filt = '0; wr_idx = '0; wr_dato = '0;
    commit = 1'b0; sel_filt = '0; muestra_tick = 1'b0;
    repeat (2) cyc();
    chk_reset_outputs("rst");
    reset = 1'b0;
    cyc();

    stream("s0_pass", 2'd0, pass_set);

    // Shadow writes without commit leave the active bank alone.
    for (int i = 0; i < 5; i++) wr(2'd1, 3'(i), set1[i]);
    stream("s1_nocommit", 2'd1, pass_set);
    chk("pend_after_writes", 32'(commit_pend), 32'd0);

    do_commit();
    stream("s1_commit", 2'd1, set1);
    chk("pend_cleared", 32'(commit_pend), 32'd0);

    // Second tick two cycles into a stream is dropped with a single overrun pulse.
    muestra_tick = 1'b1; sel_filt = 2'd0;
    cyc();
    muestra_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ovr_idx%0d", i), 32'(cte_idx), 32'(i));
      chk($sformatf("ovr_cte%0d", i), 32'(cte), 32'(pass_set[i]));
      chk($sformatf("ovr_pulse%0d", i), 32'(overrun), 32'(i == 2));
      muestra_tick = (i == 1);
      cyc();
      muestra_tick = 1'b0;
    end
    chk("ovr_end_valid", 32'(cte_valid), 32'd0);
    chk("ovr_end_pulse", 32'(overrun), 32'd0);
    cyc();
    chk("ovr_no_second", 32'(cte_valid), 32'd0);

    // Write in the tick cycle is excluded from the swap it coincides with.
    do_commit();
    wr_en = 1'b1; wr_filt = 2'd1; wr_idx = 3'd0; wr_dato = 25'h1234;
    stream("s1_tickwrite", 2'd1, set1);
    do_commit();
    stream("s1_1234", 2'd1, set1b);

    stream("sel3_pass", 2'd3, pass_set);
    wr(2'd1, 3'd5, 25'h0ABCDE);
    wr(2'd3, 3'd0, 25'h0ABCDE);
    do_commit();
    stream("s1_oor_wr", 2'd1, set1b);

    // Reset in the third cycle of a stream.
    muestra_tick = 1'b1; sel_filt = 2'd1;
    cyc();
    muestra_tick = 1'b0;
    cyc();
    cyc();
    chk("mid_idx2", 32'(cte_idx), 32'd2);
    reset = 1'b1;
    cyc();
    chk_reset_outputs("mid_rst");
    reset = 1'b0;
    cyc();
    chk("mid_rst_quiet", 32'(cte_valid), 32'd0);
    stream("post_rst_active", 2'd1, pass_set);
    do_commit();
    stream("post_rst_shadow", 2'd1, pass_set);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coef_bank_biquad.md
Name: coef_bank_biquad

Overview:
- Parametrised, run-time loadable coefficient store and sequencer for the biquad IIR filter datapath.
- Holds N_FILT coefficient sets of N_COEF words each (b0, b1, b2, a1, a2), all CANT_BITS-wide two's-complement fixed point.
- Each set lives in a shadow bank (written by the control side) and an active bank (read by the datapath).
- On each sample tick it streams the selected set, one coefficient per cycle, into the time-multiplexed MAC. Shadow-to-active commit happens only on a sample boundary, so the filter never sees a half-updated set.

Parameters:
- CANT_BITS, 25, coefficient width (two's complement).
- FRAC, 14, fractional bits; unity = 1 << FRAC (25'h4000 at defaults).
- N_FILT, 3, number of coefficient sets (filter modes).
- N_COEF, 5, coefficients per set; order b0, b1, b2, a1, a2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the shadow bank.
- wr_filt  in  clog2(N_FILT)  target set for the write.
- wr_idx  in  clog2(N_COEF)  target coefficient for the write.
- wr_dato  in  CANT_BITS  coefficient value.
- commit  in  1  pulse; request shadow->active copy at the next sample tick.
- sel_filt  in  clog2(N_FILT)  set to stream; sampled on tick.
- muestra_tick  in  1  one-cycle sample strobe; starts a stream.
- cte  out  CANT_BITS  current coefficient.
- cte_idx  out  clog2(N_COEF)  index of cte.
- cte_valid  out  1  cte/cte_idx valid this cycle.
- cte_last  out  1  high with the final coefficient of a stream.
- busy  out  1  stream in progress.
- commit_pend  out  1  commit requested, not yet applied.
- overrun  out  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset value of every set in both banks is passthrough: b0 = 1<<FRAC, all others 0.
- Reset values of outputs: cte=0, cte_idx=0, cte_valid=0, cte_last=0, busy=0, commit_pend=0, overrun=0. FSM returns to IDLE.
- Reset mid-stream aborts the stream; no further valid cycles follow.
- Writes: when wr_en=1, wr_dato goes into shadow[wr_filt][wr_idx] at the clock edge.
  - Out-of-range wr_filt or wr_idx: write ignored.
  - Writes are accepted in any state and never touch the active bank directly.
- Commit:
  - commit=1 sets commit_pend.
  - On an accepted tick with commit_pend=1, the whole shadow bank is copied to the active bank in that same edge, and commit_pend clears.
  - A write in the tick cycle lands in shadow only and is not part of that copy.
  - commit and an accepted tick in the same cycle: the pending request, if any, is applied and commit_pend stays 1 for the new request. If none was pending, nothing is copied and commit_pend becomes 1.
- FSM has two states, IDLE and RUN.
  - IDLE + muestra_tick: latch sel_filt into sel_q and perform any pending swap. Go to RUN with counter k=0; busy=1 from the next cycle.
  - RUN: each cycle drives cte_valid=1, cte_idx=k, cte=active[sel_q][k] (registered outputs). k increments; cte_last=1 when k=N_COEF-1; after that cycle, return to IDLE with busy=0.
  - Latency: first coefficient is valid the cycle after the tick. The stream occupies exactly N_COEF consecutive cycles with no gaps.
  - muestra_tick while in RUN: tick ignored, overrun pulses 1 cycle, no latch, no swap.
  - Tick in the same cycle as the final (last) coefficient counts as in RUN and is dropped.
- Out-of-range sel_filt at tick: the stream outputs passthrough coefficients (unity, 0, 0, ...) regardless of bank contents.
- The stream always reads the active bank as it was after the tick edge. Later commits do not alter an in-flight stream, because swaps occur only on accepted ticks.

Test Plan:
- Reset, then tick with sel_filt=0 -> 5 valid cycles starting 1 cycle after tick: cte=25'h4000,0,0,0,0; idx 0..4; cte_last only on idx 4; busy high for those 5 cycles.
- Write set 1 = {25'h2672, 25'h1FFB323, 25'h2672, 25'h423D, 25'h1FFE876} without commit, tick sel=1 -> still 25'h4000,0,0,0,0. Then commit and tick sel=1 -> streams the written values in order; commit_pend 1 then 0 after the tick.
- Tick asserted 2 cycles after a previous tick -> overrun pulses exactly 1 cycle; the stream continues unbroken for 5 cycles and no second stream starts.
- Commit pending, write shadow[1][0]=25'h1234 in the same cycle as an accepted tick -> active[1][0] keeps its prior committed value; a second commit plus tick makes it 25'h1234.
- Tick with sel_filt=3 (N_FILT=3) -> passthrough stream 25'h4000,0,0,0,0. Write with wr_idx=5 -> no state change.
- Assert reset in cycle 3 of a stream -> all outputs 0 the next cycle and both banks back to passthrough; the next tick streams 25'h4000,0,0,0,0.
